// File: rtl/pc_branch_if.sv
// pc_branch_if: bundles the control, jump and branch-target-table signals
// between the decode/ALU side (master) and pc_branch_ctrl (slave).
// Optional macro BRANCH_COUNT_EN adds the branch_count status bus.
interface pc_branch_if #(
    parameter int PC_W      = 10,
    parameter int LUT_IDX_W = 4
);
    logic                 start;
    logic                 jump_flag;
    logic [LUT_IDX_W-1:0] jump_idx;
    logic                 halt_req;
    logic                 stall;
    logic                 lut_we;
    logic [LUT_IDX_W-1:0] lut_waddr;
    logic [PC_W-1:0]      lut_wdata;
    logic [PC_W-1:0]      pc;
    logic                 fetch_valid;
    logic                 branch_taken;
    logic                 done;
`ifdef BRANCH_COUNT_EN
    logic [15:0]          branch_count;
`endif

    modport master (
        output start, jump_flag, jump_idx, halt_req, stall,
        output lut_we, lut_waddr, lut_wdata,
`ifdef BRANCH_COUNT_EN
        input  branch_count,
`endif
        input  pc, fetch_valid, branch_taken, done
    );

    modport slave (
        input  start, jump_flag, jump_idx, halt_req, stall,
        input  lut_we, lut_waddr, lut_wdata,
`ifdef BRANCH_COUNT_EN
        output branch_count,
`endif
        output pc, fetch_valid, branch_taken, done
    );
endinterface

// File: rtl/pc_branch_ctrl.sv
// pc_branch_ctrl: program counter and branch resolution unit. Sequences
// fetch through IDLE -> RUN -> (FLUSH after a taken branch) -> HALT and
// redirects the PC through a loadable branch-target table indexed by the
// ALU jump index. All outputs are registered.
// Optional macro BRANCH_COUNT_EN adds a saturating 16-bit count of
// accepted taken branches on bus.branch_count.
module pc_branch_ctrl #(
    parameter int          PC_W       = 10,
    parameter int          LUT_IDX_W  = 4,
    parameter int unsigned START_ADDR = 0
) (
    input logic        clk,
    input logic        reset,
    pc_branch_if.slave bus
);
    localparam int              LUT_DEPTH = 2 ** LUT_IDX_W;
    localparam logic [PC_W-1:0] START_PC  = PC_W'(START_ADDR);
    localparam logic [PC_W-1:0] PC_ONE    = {{(PC_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pc_s;
    logic            fetch_valid_r;
    logic            fetch_valid_s;
    logic            branch_taken_r;
    logic            branch_taken_s;
    logic            done_r;
    logic            done_s;
    logic            start_accept_s;
    logic            branch_accept_s;
    logic [PC_W-1:0] lut_r [LUT_DEPTH];
    logic [PC_W-1:0] lut_rdata_s;

    // Target read straight from registered storage, so a same-cycle write sees the old entry.
    always_comb begin
        lut_rdata_s = lut_r[bus.jump_idx];
    end

    // Next-state and next-output decode; halt beats jump beats stall beats increment in RUN.
    always_comb begin
        state_s         = state_r;
        pc_s            = pc_r;
        fetch_valid_s   = 1'b0;
        branch_taken_s  = 1'b0;
        done_s          = 1'b0;
        start_accept_s  = 1'b0;
        branch_accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s        = ST_RUN;
                    pc_s           = START_PC;
                    fetch_valid_s  = 1'b1;
                    start_accept_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.halt_req) begin
                    state_s = ST_HALT;
                    done_s  = 1'b1;
                end else if (bus.jump_flag) begin
                    state_s         = ST_FLUSH;
                    pc_s            = lut_rdata_s;
                    branch_taken_s  = 1'b1;
                    branch_accept_s = 1'b1;
                end else if (bus.stall) begin
                    fetch_valid_s = 1'b1;
                end else begin
                    pc_s          = pc_r + PC_ONE;
                    fetch_valid_s = 1'b1;
                end
            end
            ST_FLUSH: begin
                // The squashed slot ignores jump, stall and halt; the target is fetched next.
                state_s       = ST_RUN;
                fetch_valid_s = 1'b1;
            end
            ST_HALT: begin
                if (bus.start) begin
                    state_s        = ST_RUN;
                    pc_s           = START_PC;
                    fetch_valid_s  = 1'b1;
                    start_accept_s = 1'b1;
                end else begin
                    done_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                pc_s    = START_PC;
            end
        endcase
    end

    // State and output registers; reset discards any pending flush or branch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            pc_r           <= START_PC;
            fetch_valid_r  <= 1'b0;
            branch_taken_r <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            pc_r           <= pc_s;
            fetch_valid_r  <= fetch_valid_s;
            branch_taken_r <= branch_taken_s;
            done_r         <= done_s;
        end
    end

    // Branch-target table: cleared by reset, otherwise written in any state.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_r[i] <= {PC_W{1'b0}};
            end
        end else if (bus.lut_we) begin
            lut_r[bus.lut_waddr] <= bus.lut_wdata;
        end
    end

    assign bus.pc           = pc_r;
    assign bus.fetch_valid  = fetch_valid_r;
    assign bus.branch_taken = branch_taken_r;
    assign bus.done         = done_r;

`ifdef BRANCH_COUNT_EN
    logic [15:0] branch_count_r;

    // Saturating count of accepted taken branches, restarted by every accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_count_r <= 16'h0000;
        end else if (start_accept_s) begin
            branch_count_r <= 16'h0000;
        end else if (branch_accept_s && (branch_count_r != 16'hFFFF)) begin
            branch_count_r <= branch_count_r + 16'h0001;
        end
    end

    assign bus.branch_count = branch_count_r;
`else
    logic unused_accept_s;

    // Accept strobes only feed the optional counter; fold them so they stay referenced.
    always_comb begin
        unused_accept_s = start_accept_s & branch_accept_s;
    end
`endif
endmodule

// File: tb/tb_pc_branch_ctrl.sv
// tb_pc_branch_ctrl: scoreboard bench for pc_branch_ctrl. A stimulus process
// drives inputs on the falling edge, runs a behavioural program-sequencer
// model and queues the expected registered outputs; a monitor pops and
// compares one record per rising edge. Honours BRANCH_COUNT_EN when defined.
module tb_pc_branch_ctrl;
    localparam int PC_W      = 10;
    localparam int LUT_IDX_W = 4;
    localparam int DEPTH     = 16;
    localparam int PC_MOD    = 1024;

    logic clk = 1'b0;
    logic reset;

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    pc_branch_if #(.PC_W(PC_W), .LUT_IDX_W(LUT_IDX_W)) bus ();

    pc_branch_ctrl #(.PC_W(PC_W), .LUT_IDX_W(LUT_IDX_W), .START_ADDR(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int pc;
        int fv;
        int bt;
        int dn;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural model: a program is either not started, running (possibly
    // inside its one-cycle squash bubble) or halted.
    bit m_running;
    bit m_bubble;
    bit m_halted;
    int m_pc;
    int m_cnt;
    int m_lut[DEPTH];

    function automatic void chk(string name, int act, int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, expv, $time);
        end
    endfunction

    task automatic model_step(bit rst, bit st, bit jf, int idx, bit hr, bit sl,
                              bit we, int wa, int wd);
        exp_t e;
        int   target;
        if (rst) begin
            m_running = 1'b0;
            m_bubble  = 1'b0;
            m_halted  = 1'b0;
            m_pc      = 0;
            m_cnt     = 0;
            foreach (m_lut[i]) m_lut[i] = 0;
        end else begin
            target = m_lut[idx];
            if (m_bubble) begin
                m_bubble = 1'b0;
            end else if (m_running) begin
                if (hr) begin
                    m_running = 1'b0;
                    m_halted  = 1'b1;
                end else if (jf) begin
                    m_pc     = target;
                    m_bubble = 1'b1;
                    if (m_cnt < 65535) m_cnt = m_cnt + 1;
                end else if (!sl) begin
                    m_pc = (m_pc + 1) % PC_MOD;
                end
            end else if (st) begin
                m_running = 1'b1;
                m_halted  = 1'b0;
                m_pc      = 0;
                m_cnt     = 0;
            end
            if (we) m_lut[wa] = wd;
        end
        e.pc  = m_pc;
        e.fv  = (m_running && !m_bubble) ? 1 : 0;
        e.bt  = m_bubble ? 1 : 0;
        e.dn  = m_halted ? 1 : 0;
        e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic apply(bit rst, bit st, bit jf, int idx, bit hr, bit sl,
                         bit we, int wa, int wd);
        reset         = rst;
        bus.start     = st;
        bus.jump_flag = jf;
        bus.jump_idx  = LUT_IDX_W'(idx);
        bus.halt_req  = hr;
        bus.stall     = sl;
        bus.lut_we    = we;
        bus.lut_waddr = LUT_IDX_W'(wa);
        bus.lut_wdata = PC_W'(wd);
        model_step(rst, st, jf, idx, hr, sl, we, wa, wd);
        @(negedge clk);
    endtask

    task automatic nop(int n);
        repeat (n) apply(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic jump(int idx);
        apply(1'b0, 1'b0, 1'b1, idx, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic lut_write(int wa, int wd);
        apply(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, wa, wd);
    endtask

    task automatic do_start();
        apply(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    // Monitor: every rising edge with a queued record, compare the registered outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc", int'(bus.pc), e.pc);
                chk("fetch_valid", int'(bus.fetch_valid), e.fv);
                chk("branch_taken", int'(bus.branch_taken), e.bt);
                chk("done", int'(bus.done), e.dn);
`ifdef BRANCH_COUNT_EN
                chk("branch_count", int'(bus.branch_count), e.cnt);
`endif
            end
        end
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, failures so far %0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    // Stimulus: directed scenarios followed by a randomized phase.
    initial begin
        // Reset and basic sequencing.
        apply(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
        apply(1'b1, 1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b1, 3, 77);
        nop(2);
        do_start();
        nop(3);

        // Jump through LUT[5]=0x123, then a jump attempt inside FLUSH.
        lut_write(5, 'h123);
        nop(3);
        jump(5);
        nop(3);

        // Stall, halt beats jump, restart.
        apply(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 0);
        do_start();
        nop(4);
        repeat (3) apply(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
        apply(1'b0, 1'b0, 1'b1, 5, 1'b1, 1'b1, 1'b0, 0, 0);
        nop(2);
        apply(1'b0, 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0, 0, 0);
        do_start();
        nop(2);

        // Wrap from 0x3FF to 0.
        lut_write(1, 'h3FF);
        jump(1);
        nop(4);

        // Read-before-write, then jump, halt and stall ignored during FLUSH.
        lut_write(2, 'h020);
        apply(1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b1, 2, 'h050);
        apply(1'b0, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b0, 0, 0);
        nop(2);
        jump(2);
        nop(2);

        // Three branches, then reset mid-run.
        jump(5);
        nop(1);
        jump(1);
        nop(1);
        jump(2);
        nop(2);
        apply(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
        nop(2);
        do_start();
        jump(5);
        nop(2);

        // Randomized phase with table preload.
        for (int i = 0; i < DEPTH; i++) lut_write(i, int'($urandom_range(0, PC_MOD - 1)));
        for (int n = 0; n < 600; n++) begin
            apply($urandom_range(0, 79) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0,
                  int'($urandom_range(0, DEPTH - 1)),
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 2) == 0,
                  int'($urandom_range(0, DEPTH - 1)),
                  int'($urandom_range(0, PC_MOD - 1)));
        end
        nop(2);

        @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_branch_ctrl.md
Name: pc_branch_ctrl

Overview:
- Program-counter and branch-resolution unit; the consuming end of the ALU's jump interface.
- Takes the ALU jump flag plus a 4-bit target index (ALU output low bits) and redirects fetch through a loadable branch-target lookup table.
- Sequences fetch: idle, run, one-cycle flush bubble after a taken branch, halt. Drives the instruction-memory address and the top-level done.

Parameters:
PC_W, 10, program counter width; instruction address space 2^PC_W.
LUT_IDX_W, 4, branch-target LUT index width; depth 2^LUT_IDX_W.
START_ADDR, 0, PC value loaded on start.

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  begin execution from START_ADDR; honoured in IDLE and HALT only.
jump_flag  input  1  ALU branch-taken indication for the instruction at pc; sampled in RUN only.
jump_idx  input  LUT_IDX_W  branch-target LUT index, qualified by jump_flag.
halt_req  input  1  decoded halt instruction.
stall  input  1  hold pc this cycle; RUN only.
lut_we  input  1  LUT write enable.
lut_waddr  input  LUT_IDX_W  LUT write index.
lut_wdata  input  PC_W  LUT write data (absolute target address).
pc  output  PC_W  current fetch address.
fetch_valid  output  1  pc holds a valid instruction to execute this cycle.
branch_taken  output  1  one-cycle pulse, the cycle after a taken branch is accepted.
done  output  1  program halted; held until the next start.

Behaviour:
- All state updates on rising clk. Reset is synchronous and active-high and overrides every other input.
- Reset values: state=IDLE, pc=START_ADDR, fetch_valid=0, branch_taken=0, done=0. All LUT entries are cleared to 0.
- FSM states: IDLE, RUN, FLUSH, HALT.
- IDLE:
  - start=1 -> RUN; pc=START_ADDR; fetch_valid=1.
  - Otherwise hold all outputs at 0 and pc unchanged.
- RUN: fetch_valid=1. Input priority is halt_req > jump_flag > stall > increment.
  - halt_req=1 -> HALT next cycle; pc holds; fetch_valid=0; done=1.
  - jump_flag=1 -> pc<=LUT[jump_idx]; branch_taken=1 for exactly the next cycle; state FLUSH.
  - stall=1 -> pc holds; stays in RUN.
  - Otherwise pc<=pc+1, modulo 2^PC_W (2^PC_W-1 wraps to 0).
  - start is ignored in RUN.
- FLUSH: exactly one cycle.
  - fetch_valid=0; pc holds the branch target.
  - jump_flag and stall are ignored (instruction squashed). Next state is RUN with pc unchanged, so the target is fetched with fetch_valid=1.
  - halt_req in FLUSH is also ignored.
- HALT:
  - done=1, fetch_valid=0, pc frozen.
  - start=1 -> RUN; pc=START_ADDR; done cleared the same edge.
- branch_taken is 0 in every cycle except the one following an accepted jump.
- LUT writes:
  - Accepted in every state except during reset. Write takes effect at the edge.
  - A jump in the same cycle as a write to the same index uses the old entry (read-before-write).
  - LUT read is combinational from registered storage.
- Mid-operation reset (any state) returns to IDLE next edge. Any pending flush or branch is discarded.

Optional Feature:
- Macro BRANCH_COUNT_EN.
- Defined:
  - Adds output branch_count, 16 bits: counts accepted taken branches.
  - Saturates at 16'hFFFF.
  - Cleared on reset and on any accepted start.
  - Updates on the same edge pc loads the target.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then start=1 for 1 cycle -> pc=0, fetch_valid=1. With no inputs, pc=1,2,3 on consecutive cycles; done=0.
- Load LUT[5]=10'h123, run to pc=7, pulse jump_flag=1 with jump_idx=5 -> next cycle pc=0x123, branch_taken=1, fetch_valid=0. Following cycle: fetch_valid=1, pc=0x123, branch_taken=0.
- Assert stall for 3 cycles at pc=4 -> pc stays 4. Same cycle halt_req=1 and jump_flag=1 -> halt wins: done=1, pc=4 frozen, fetch_valid=0. Then start=1 -> pc=0, done=0.
- Force pc to 0x3FF via LUT jump (LUT[1]=0x3FF), let it run -> after the flush cycle pc goes 0x3FF then 0x000.
- Same cycle: lut_we=1, lut_waddr=2, lut_wdata=0x050, old LUT[2]=0x020, jump_flag=1, jump_idx=2 -> pc=0x020. Next jump via idx 2 -> pc=0x050. A jump_flag asserted during FLUSH is ignored.
- BRANCH_COUNT_EN defined: 3 taken branches -> branch_count=3. Assert reset in RUN mid-stream -> next cycle state IDLE, pc=0, branch_count=0, fetch_valid=0.
